// File: rtl/multi_cycle_control_if.sv
// Control bus between the multi-cycle FSM and the datapath.
// The FSM drives the master side; the datapath is the slave.
interface multi_cycle_control_if #(
   parameter int CNT_W = 16
);
   logic [5:0]       opcode;
   logic             zero;
   logic [2:0]       state;
   logic             pc_write;
   logic [1:0]       pc_src;
   logic             ir_write;
   logic             mem_read;
   logic             mem_write;
   logic             reg_write;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             alu_src_a;
   logic             alu_src_b;
   logic             ext_sel;
   logic [1:0]       aluop;
   logic             halted;
   logic [CNT_W-1:0] instr_cnt;

   modport master (
      input  opcode, zero,
      output state, pc_write, pc_src, ir_write,
      output mem_read, mem_write, reg_write,
      output reg_dst, mem_to_reg, alu_src_a,
      output alu_src_b, ext_sel, aluop,
      output halted, instr_cnt
   );

   modport slave (
      output opcode, zero,
      input  state, pc_write, pc_src, ir_write,
      input  mem_read, mem_write, reg_write,
      input  reg_dst, mem_to_reg, alu_src_a,
      input  alu_src_b, ext_sel, aluop,
      input  halted, instr_cnt
   );
endinterface

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle CPU: IF/ID/EXE/MEM/WB
// sequencing, datapath selects, retire counter and HALT.
module multi_cycle_control #(
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   multi_cycle_control_if.master bus
);

   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EXE  = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd7;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             retire;

   logic is_r, is_sll, is_i, is_zext;
   logic is_lw, is_sw, is_beq, is_bne;
   logic is_bltz, is_j, is_halt;

   logic       pc_w, ir_w, mem_w, reg_w;
   logic       mem_r, rdst, m2r, src_a, src_b, ext;
   logic [1:0] pcs, aop;
   logic       hlt;

   // Opcode class decode; anything unmatched is a nop.
   always_comb begin
      is_r    = 1'b0;
      is_sll  = 1'b0;
      is_i    = 1'b0;
      is_zext = 1'b0;
      is_lw   = 1'b0;
      is_sw   = 1'b0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      is_bltz = 1'b0;
      is_j    = 1'b0;
      is_halt = 1'b0;
      unique case (bus.opcode)
         6'b000000, 6'b000001,
         6'b010001, 6'b010011: is_r = 1'b1;
         6'b011000: begin
            is_r   = 1'b1;
            is_sll = 1'b1;
         end
         6'b000010, 6'b011100: is_i = 1'b1;
         6'b010000, 6'b010010: begin
            is_i    = 1'b1;
            is_zext = 1'b1;
         end
         6'b100110: is_sw   = 1'b1;
         6'b100111: is_lw   = 1'b1;
         6'b110000: is_beq  = 1'b1;
         6'b110001: is_bne  = 1'b1;
         6'b110010: is_bltz = 1'b1;
         6'b111000: is_j    = 1'b1;
         6'b111111: is_halt = 1'b1;
         default: ;
      endcase
   end

   // Per-state control outputs, next state and retire pulse.
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      pc_w    = 1'b0;
      pcs     = 2'd0;
      ir_w    = 1'b0;
      mem_r   = 1'b0;
      mem_w   = 1'b0;
      reg_w   = 1'b0;
      rdst    = 1'b0;
      m2r     = 1'b0;
      src_a   = 1'b0;
      src_b   = 1'b0;
      ext     = 1'b0;
      aop     = 2'd0;
      hlt     = 1'b0;
      case (state_q)
         S_IF: begin
            ir_w    = 1'b1;
            pc_w    = 1'b1;
            state_d = S_ID;
         end
         S_ID: begin
            state_d = S_EXE;
            if (is_j) begin
               pc_w    = 1'b1;
               pcs     = 2'd2;
               state_d = S_IF;
               retire  = 1'b1;
            end else if (is_halt) begin
               state_d = S_HALT;
               retire  = 1'b1;
            end else if (!(is_r | is_i | is_lw | is_sw |
                           is_beq | is_bne | is_bltz)) begin
               state_d = S_IF;
               retire  = 1'b1;
            end
         end
         S_EXE: begin
            state_d = S_IF;
            unique case (1'b1)
               is_r: begin
                  aop     = 2'd2;
                  rdst    = 1'b1;
                  src_a   = is_sll;
                  state_d = S_WB;
               end
               is_i: begin
                  aop     = 2'd2;
                  src_b   = 1'b1;
                  ext     = ~is_zext;
                  state_d = S_WB;
               end
               is_lw, is_sw: begin
                  src_b   = 1'b1;
                  ext     = 1'b1;
                  state_d = S_MEM;
               end
               is_beq, is_bne: begin
                  aop    = 2'd1;
                  ext    = 1'b1;
                  pcs    = 2'd1;
                  pc_w   = is_beq ? bus.zero : ~bus.zero;
                  retire = 1'b1;
               end
               is_bltz: begin
                  aop    = 2'd2;
                  pcs    = 2'd1;
                  pc_w   = ~bus.zero;
                  retire = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            if (is_sw) begin
               mem_w   = 1'b1;
               state_d = S_IF;
               retire  = 1'b1;
            end else begin
               mem_r   = 1'b1;
               state_d = S_WB;
            end
         end
         S_WB: begin
            reg_w   = 1'b1;
            rdst    = is_r;
            m2r     = is_lw;
            state_d = S_IF;
            retire  = 1'b1;
         end
         S_HALT: begin
            hlt     = 1'b1;
            state_d = S_HALT;
         end
         default: state_d = S_IF;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IF;
      else        state_q <= state_d;
   end

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt_q <= '0;
      else if (retire) cnt_q <= cnt_q + 1'b1;
   end

   // Strobes are held off while reset is asserted.
   assign bus.pc_write   = pc_w  & rst_n;
   assign bus.ir_write   = ir_w  & rst_n;
   assign bus.mem_write  = mem_w & rst_n;
   assign bus.reg_write  = reg_w & rst_n;
   assign bus.state      = state_q;
   assign bus.pc_src     = pcs;
   assign bus.mem_read   = mem_r;
   assign bus.reg_dst    = rdst;
   assign bus.mem_to_reg = m2r;
   assign bus.alu_src_a  = src_a;
   assign bus.alu_src_b  = src_b;
   assign bus.ext_sel    = ext;
   assign bus.aluop      = aop;
   assign bus.halted     = hlt;
   assign bus.instr_cnt  = cnt_q;

endmodule
